// File: rtl/encoder_pkg.sv
// encoder_pkg: shared types and helpers for the bit-scan encoder.
//   enc_state_t    : scanner FSM state (IDLE waits for a vector, BUSY emits beats)
//   vec_width(n)   : width of the scanned vector for an index width of n
package encoder_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } enc_state_t;

    function automatic int vec_width(input int n);
        return 2 ** n;
    endfunction

endpackage

// File: rtl/priority_encoder.sv
// priority_encoder: purely combinational lowest-set-bit encoder.
//   vec    [2**N-1:0] in  : vector to inspect
//   idx    [N-1:0]    out : index of the lowest set bit (0 when vec is zero)
//   any               out : vec has at least one bit set
//   single            out : vec has at most one bit set
module priority_encoder
    import encoder_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [vec_width(N)-1:0] vec,
    output logic [N-1:0]            idx,
    output logic                    any,
    output logic                    single
);

    localparam int W = vec_width(N);

    // Two's-complement trick isolates the lowest set bit as a one-hot word.
    logic [W-1:0] lowest_onehot;
    assign lowest_onehot = vec & (~vec + W'(1));

    // OR-chain of the index of the (only) hot bit; no priority mux is needed
    // because lowest_onehot has at most one bit set.
    logic [W:0][N-1:0] idx_chain;
    assign idx_chain[0] = '0;

    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_idx
            localparam logic [N-1:0] BIT_IDX = N'(gi);
            assign idx_chain[gi+1] = idx_chain[gi] | (lowest_onehot[gi] ? BIT_IDX : '0);
        end
    endgenerate

    assign idx    = idx_chain[W];
    assign any    = |vec;
    // Clearing the lowest set bit leaves nothing iff at most one bit was set.
    assign single = ((vec & (vec - W'(1))) == '0);

endmodule

// File: rtl/encoder_scan.sv
// encoder_scan: sequential bit-scan encoder.
// Accepts a 2**N-bit vector over valid/ready and emits the index of every set
// bit, lowest first, one per output handshake, flagging the final beat with
// last. An all-zero vector yields a single beat with zero=1, last=1, a=0.
//   clk, rst (async, active-high)
//   in_valid / in_ready / d [2**N-1:0]   : input vector handshake
//   out_valid / out_ready                : output beat handshake
//   a [N-1:0]  : index of the lowest pending set bit
//   last       : current beat is the final one for this vector
//   zero       : accepted vector was all zeros
module encoder_scan
    import encoder_pkg::*;
#(
    parameter int N = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [vec_width(N)-1:0] d,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [N-1:0]            a,
    output logic                    last,
    output logic                    zero
);

    localparam int W = vec_width(N);

    enc_state_t   state_reg;
    logic [W-1:0] pending_reg;

    logic [N-1:0] pe_idx;
    logic         pe_any;
    logic         pe_single;

    priority_encoder #(.N(N)) u_pe (
        .vec    (pending_reg),
        .idx    (pe_idx),
        .any    (pe_any),
        .single (pe_single)
    );

    logic busy;
    assign busy = (state_reg == BUSY);

    // Beat fields come straight from the registered pending vector, so they
    // stay stable while out_ready is low. They are gated with busy so that
    // IDLE presents all-zero outputs (pending==0 would otherwise read zero=1).
    assign out_valid = busy;
    assign a         = busy ? pe_idx : '0;
    assign zero      = busy & ~pe_any;
    assign last      = busy & pe_single;

    logic out_fire;
    assign out_fire = out_valid & out_ready;

    // Accepting on the final beat lets back-to-back vectors stream without
    // an idle cycle; this makes in_ready combinational from out_ready.
    assign in_ready = ~busy | (out_fire & last);

    // Pending vector with the index being emitted this beat removed.
    logic [W-1:0] cleared_next;
    assign cleared_next = pending_reg & ~(W'(1) << pe_idx);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            pending_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        pending_reg <= d;
                        state_reg   <= BUSY;
                    end
                end
                BUSY: begin
                    if (out_ready) begin
                        if (!last) begin
                            pending_reg <= cleared_next;
                        end else if (in_valid) begin
                            pending_reg <= d;
                        end else begin
                            pending_reg <= '0;
                            state_reg   <= IDLE;
                        end
                    end
                end
                default: begin
                    state_reg   <= IDLE;
                    pending_reg <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_encoder_scan.sv
// Testbench for encoder_scan: N=2 instance for table vectors and multi-cycle
// corner cases, N=3 instance for an 8-bit scan under random back-pressure.
module tb_encoder_scan;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // N=2 instance
    logic       in_valid = 1'b0, out_ready = 1'b0;
    logic [3:0] d = '0;
    logic       in_ready, out_valid, last, zero;
    logic [1:0] a;

    encoder_scan #(.N(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .d(d),
        .out_valid(out_valid), .out_ready(out_ready), .a(a), .last(last), .zero(zero)
    );

    // N=3 instance
    logic       in_valid3 = 1'b0, out_ready3 = 1'b0;
    logic [7:0] d3 = '0;
    logic       in_ready3, out_valid3, last3, zero3;
    logic [2:0] a3;

    encoder_scan #(.N(3)) dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid3), .in_ready(in_ready3), .d(d3),
        .out_valid(out_valid3), .out_ready(out_ready3), .a(a3), .last(last3), .zero(zero3)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0]      d;
        int              nbeats;
        logic [3:0][1:0] exp_a;  // beat b expects exp_a[b]
        logic            exp_zero;
    } vec_t;

    vec_t vecs[7];

    initial begin
        vecs[0] = '{d: 4'b1010, nbeats: 1 + 1, exp_a: {2'd0, 2'd0, 2'd3, 2'd1}, exp_zero: 1'b0};
        vecs[1] = '{d: 4'b0000, nbeats: 1,     exp_a: {2'd0, 2'd0, 2'd0, 2'd0}, exp_zero: 1'b1};
        vecs[2] = '{d: 4'b0001, nbeats: 1,     exp_a: {2'd0, 2'd0, 2'd0, 2'd0}, exp_zero: 1'b0};
        vecs[3] = '{d: 4'b1000, nbeats: 1,     exp_a: {2'd0, 2'd0, 2'd0, 2'd3}, exp_zero: 1'b0};
        vecs[4] = '{d: 4'b0111, nbeats: 3,     exp_a: {2'd0, 2'd2, 2'd1, 2'd0}, exp_zero: 1'b0};
        vecs[5] = '{d: 4'b1111, nbeats: 4,     exp_a: {2'd3, 2'd2, 2'd1, 2'd0}, exp_zero: 1'b0};
        vecs[6] = '{d: 4'b0100, nbeats: 1,     exp_a: {2'd0, 2'd0, 2'd0, 2'd2}, exp_zero: 1'b0};

        // ---------------- reset state ----------------
        #2;
        chk("rst in_ready",  32'(in_ready), 32'd1);
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst a",         32'(a), 32'd0);
        chk("rst last",      32'(last), 32'd0);
        chk("rst zero",      32'(zero), 32'd0);
        chk("rst3 in_ready", 32'(in_ready3), 32'd1);
        chk("rst3 out_valid",32'(out_valid3), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // ---------------- table-driven vectors ----------------
        for (int v = 0; v < 7; v++) begin
            @(negedge clk);
            in_valid  = 1'b1;
            d         = vecs[v].d;
            out_ready = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            for (int b = 0; b < vecs[v].nbeats; b++) begin
                $display("vec %0d d=%b beat %0d: a=%0d last=%0d zero=%0d", v, vecs[v].d, b, a, last, zero);
                chk($sformatf("v%0d b%0d out_valid", v, b), 32'(out_valid), 32'd1);
                chk($sformatf("v%0d b%0d a", v, b), 32'(a), 32'(vecs[v].exp_a[b]));
                chk($sformatf("v%0d b%0d last", v, b), 32'(last), 32'(b == vecs[v].nbeats - 1));
                chk($sformatf("v%0d b%0d zero", v, b), 32'(zero), 32'(vecs[v].exp_zero));
                @(negedge clk);
            end
            chk($sformatf("v%0d idle out_valid", v), 32'(out_valid), 32'd0);
            chk($sformatf("v%0d idle in_ready", v), 32'(in_ready), 32'd1);
        end

        // ---------------- back-pressure hold: d=0110 ----------------
        @(negedge clk);
        in_valid = 1'b1; d = 4'b0110; out_ready = 1'b0;
        @(negedge clk);
        // stray vector offered while busy must be ignored
        d = 4'b1111;
        for (int c = 0; c < 3; c++) begin
            $display("hold cycle %0d: a=%0d out_valid=%0d in_ready=%0d", c, a, out_valid, in_ready);
            chk($sformatf("hold%0d out_valid", c), 32'(out_valid), 32'd1);
            chk($sformatf("hold%0d a", c), 32'(a), 32'd1);
            chk($sformatf("hold%0d last", c), 32'(last), 32'd0);
            chk($sformatf("hold%0d in_ready", c), 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        chk("hold rel a1", 32'(a), 32'd1);
        chk("hold rel last1", 32'(last), 32'd0);
        @(negedge clk);
        chk("hold rel a2", 32'(a), 32'd2);
        chk("hold rel last2", 32'(last), 32'd1);
        @(negedge clk);
        chk("hold done out_valid", 32'(out_valid), 32'd0);

        // ---------------- back-to-back: 0001 then 1000 ----------------
        @(negedge clk);
        in_valid = 1'b1; d = 4'b0001; out_ready = 1'b1;
        @(negedge clk);
        d = 4'b1000;
        $display("b2b beat 0: a=%0d last=%0d in_ready=%0d", a, last, in_ready);
        chk("b2b0 out_valid", 32'(out_valid), 32'd1);
        chk("b2b0 a", 32'(a), 32'd0);
        chk("b2b0 last", 32'(last), 32'd1);
        chk("b2b0 in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        $display("b2b beat 1: a=%0d last=%0d out_valid=%0d", a, last, out_valid);
        chk("b2b1 out_valid", 32'(out_valid), 32'd1);
        chk("b2b1 a", 32'(a), 32'd3);
        chk("b2b1 last", 32'(last), 32'd1);
        @(negedge clk);
        chk("b2b done out_valid", 32'(out_valid), 32'd0);

        // ---------------- reset mid-scan: 1111 ----------------
        @(negedge clk);
        in_valid = 1'b1; d = 4'b1111; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("rms a0", 32'(a), 32'd0);
        @(negedge clk);
        chk("rms a1", 32'(a), 32'd1);
        @(negedge clk);
        chk("rms a2 pre-rst", 32'(a), 32'd2);
        #2 rst = 1'b1;
        #1;
        $display("mid-scan reset: out_valid=%0d a=%0d in_ready=%0d", out_valid, a, in_ready);
        chk("rms out_valid", 32'(out_valid), 32'd0);
        chk("rms a", 32'(a), 32'd0);
        chk("rms last", 32'(last), 32'd0);
        chk("rms zero", 32'(zero), 32'd0);
        chk("rms in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("post-rst%0d out_valid", c), 32'(out_valid), 32'd0);
            chk($sformatf("post-rst%0d in_ready", c), 32'(in_ready), 32'd1);
        end

        // ---------------- N=3, 8'hFF, random out_ready ----------------
        begin
            int count;
            int budget;
            count  = 0;
            budget = 0;
            @(negedge clk);
            in_valid3 = 1'b1; d3 = 8'hFF; out_ready3 = 1'b0;
            @(negedge clk);
            in_valid3 = 1'b0;
            while (budget < 300) begin
                out_ready3 = 1'($urandom_range(0, 1));
                #1;
                if (out_valid3 && out_ready3) begin
                    $display("n3 beat %0d: a=%0d last=%0d", count, a3, last3);
                    chk($sformatf("n3 b%0d a", count), 32'(a3), 32'(count));
                    chk($sformatf("n3 b%0d last", count), 32'(last3), 32'(count == 7));
                    count++;
                    if (last3) begin
                        @(negedge clk);
                        break;
                    end
                end
                @(negedge clk);
                budget++;
            end
            chk("n3 beat count", 32'(count), 32'd8);
            chk("n3 done out_valid", 32'(out_valid3), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
